// File: rtl/rob_alloc_commit_ctrl.sv
// Reorder-buffer sequencer: allocates tail entries, retires the head in order, truncates on mispredict.
// Define ROB_CTRL_STATS_EN to add saturating commit/flush statistics counters.
module rob_alloc_commit_ctrl #(
    parameter int ROB_SIZE     = 8,
    parameter int ROB_IDX_SIZE = 3,
    parameter int GPR_IDX_SIZE = 5
) (
    input  logic                    in_clk,
    input  logic                    in_rst_n,
    input  logic                    in_alloc_valid,
    input  logic [GPR_IDX_SIZE-1:0] in_alloc_gpr_idx,
    input  logic                    in_alloc_is_nop,
    output logic                    out_alloc_ready,
    output logic [ROB_IDX_SIZE-1:0] out_alloc_idx,
    input  logic                    in_fu_done,
    input  logic [ROB_IDX_SIZE-1:0] in_fu_rob_idx,
    input  logic                    in_mispred,
    input  logic [ROB_IDX_SIZE-1:0] in_mispred_rob_idx,
    input  logic                    in_commit_ready,
    output logic                    out_commit_valid,
    output logic [ROB_IDX_SIZE-1:0] out_commit_idx,
    output logic [GPR_IDX_SIZE-1:0] out_commit_gpr_idx,
    output logic                    out_regfile_should_commit,
`ifdef ROB_CTRL_STATS_EN
    output logic [31:0]             out_stat_commits,
    output logic [15:0]             out_stat_flushes,
`endif
    output logic [ROB_IDX_SIZE:0]   out_count
);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    localparam logic [ROB_IDX_SIZE:0] FULL_COUNT = (ROB_IDX_SIZE+1)'(ROB_SIZE);

    state_t                  state, state_next;
    logic [ROB_IDX_SIZE-1:0] head, tail;
    logic [ROB_IDX_SIZE:0]   count;
    logic [ROB_SIZE-1:0]     busy, done, is_nop, younger;
    logic [GPR_IDX_SIZE-1:0] gpr [ROB_SIZE];
    logic                    grant, fire, mispred_accept;
    logic [ROB_IDX_SIZE-1:0] branch_dist;
    logic [ROB_IDX_SIZE:0]   grant_ext, fire_ext;

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) state <= ST_RUN;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (mispred_accept) state_next = ST_FLUSH;
            ST_FLUSH: state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    // Handshake outputs stay low while reset is held, whatever the registers contain.
    always_comb begin
        out_alloc_ready  = 1'b0;
        out_commit_valid = 1'b0;
        if (in_rst_n && state == ST_RUN) begin
            out_alloc_ready  = (count < FULL_COUNT) && !in_mispred;
            out_commit_valid = busy[head] && done[head];
        end
    end

    assign out_alloc_idx             = tail;
    assign out_commit_idx            = head;
    assign out_commit_gpr_idx        = gpr[head];
    assign out_regfile_should_commit = out_commit_valid && !is_nop[head];
    assign out_count                 = count;

    assign grant          = in_alloc_valid && out_alloc_ready;
    assign fire           = out_commit_valid && in_commit_ready;
    assign mispred_accept = in_mispred && (state == ST_RUN) && busy[in_mispred_rob_idx];
    assign grant_ext      = {{ROB_IDX_SIZE{1'b0}}, grant};
    assign fire_ext       = {{ROB_IDX_SIZE{1'b0}}, fire};

    // Age is the distance from head, so "younger than the branch" works across wrap and when full.
    always_comb begin
        logic [ROB_IDX_SIZE-1:0] entry_dist;
        branch_dist = in_mispred_rob_idx - head;
        younger     = '0;
        for (int j = 0; j < ROB_SIZE; j++) begin
            entry_dist = ROB_IDX_SIZE'(j) - head;
            younger[j] = entry_dist > branch_dist;
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            busy   <= '0;
            done   <= '0;
            is_nop <= '0;
            for (int j = 0; j < ROB_SIZE; j++) gpr[j] <= '0;
        end else begin
            if (in_fu_done && busy[in_fu_rob_idx]) done[in_fu_rob_idx] <= 1'b1;
            if (grant) begin
                busy[tail]   <= 1'b1;
                done[tail]   <= 1'b0;
                is_nop[tail] <= in_alloc_is_nop;
                gpr[tail]    <= in_alloc_gpr_idx;
                tail         <= tail + ROB_IDX_SIZE'(1);
            end
            if (fire) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
                head       <= head + ROB_IDX_SIZE'(1);
            end
            if (mispred_accept) begin
                tail <= in_mispred_rob_idx + ROB_IDX_SIZE'(1);
                for (int j = 0; j < ROB_SIZE; j++) begin
                    if (younger[j]) begin
                        busy[j] <= 1'b0;
                        done[j] <= 1'b0;
                    end
                end
                count <= {1'b0, branch_dist} + (ROB_IDX_SIZE+1)'(1) - fire_ext;
            end else begin
                count <= count + grant_ext - fire_ext;
            end
        end
    end

`ifdef ROB_CTRL_STATS_EN
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            out_stat_commits <= '0;
            out_stat_flushes <= '0;
        end else begin
            if (fire && out_stat_commits != '1) out_stat_commits <= out_stat_commits + 32'd1;
            if (mispred_accept && out_stat_flushes != '1) out_stat_flushes <= out_stat_flushes + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_alloc_commit_ctrl.sv
// Randomized bench for rob_alloc_commit_ctrl against a queue-based program-order model.
module tb_rob_alloc_commit_ctrl;

    typedef struct {
        int idx;
        int gpr;
        bit nop;
        bit done;
    } entry_t;

    logic       in_clk = 1'b0;
    logic       in_rst_n;
    logic       in_alloc_valid;
    logic [4:0] in_alloc_gpr_idx;
    logic       in_alloc_is_nop;
    logic       out_alloc_ready;
    logic [2:0] out_alloc_idx;
    logic       in_fu_done;
    logic [2:0] in_fu_rob_idx;
    logic       in_mispred;
    logic [2:0] in_mispred_rob_idx;
    logic       in_commit_ready;
    logic       out_commit_valid;
    logic [2:0] out_commit_idx;
    logic [4:0] out_commit_gpr_idx;
    logic       out_regfile_should_commit;
    logic [3:0] out_count;

    entry_t m_q[$];
    int     m_head;
    bit     m_flush;
    int     n_checks = 0;
    int     n_errors = 0;

    rob_alloc_commit_ctrl dut (
        .in_clk(in_clk),
        .in_rst_n(in_rst_n),
        .in_alloc_valid(in_alloc_valid),
        .in_alloc_gpr_idx(in_alloc_gpr_idx),
        .in_alloc_is_nop(in_alloc_is_nop),
        .out_alloc_ready(out_alloc_ready),
        .out_alloc_idx(out_alloc_idx),
        .in_fu_done(in_fu_done),
        .in_fu_rob_idx(in_fu_rob_idx),
        .in_mispred(in_mispred),
        .in_mispred_rob_idx(in_mispred_rob_idx),
        .in_commit_ready(in_commit_ready),
        .out_commit_valid(out_commit_valid),
        .out_commit_idx(out_commit_idx),
        .out_commit_gpr_idx(out_commit_gpr_idx),
        .out_regfile_should_commit(out_regfile_should_commit),
        .out_count(out_count)
    );

    always #5 in_clk = ~in_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Holds reset for the given cycles with random traffic on every other input.
    task automatic applyReset(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            in_rst_n           = 1'b0;
            in_alloc_valid     = 1'($urandom);
            in_alloc_gpr_idx   = 5'($urandom);
            in_alloc_is_nop    = 1'($urandom);
            in_fu_done         = 1'($urandom);
            in_fu_rob_idx      = 3'($urandom);
            in_mispred         = 1'($urandom);
            in_mispred_rob_idx = 3'($urandom);
            in_commit_ready    = 1'($urandom);
            #1;
            checkOutput("rst_alloc_ready_comb", 32'(out_alloc_ready), 32'd0);
            checkOutput("rst_commit_valid_comb", 32'(out_commit_valid), 32'd0);
            @(posedge in_clk);
            @(negedge in_clk);
            checkOutput("rst_alloc_ready", 32'(out_alloc_ready), 32'd0);
            checkOutput("rst_commit_valid", 32'(out_commit_valid), 32'd0);
            checkOutput("rst_should_commit", 32'(out_regfile_should_commit), 32'd0);
            checkOutput("rst_alloc_idx", 32'(out_alloc_idx), 32'd0);
            checkOutput("rst_commit_idx", 32'(out_commit_idx), 32'd0);
            checkOutput("rst_count", 32'(out_count), 32'd0);
        end
        m_q.delete();
        m_head  = 0;
        m_flush = 1'b0;
    endtask

    // One cycle: drive inputs, compare outputs to the model, then advance the model past the edge.
    task automatic applyStimulus(input logic av, input logic [4:0] ag, input logic an,
                                 input logic fd, input logic [2:0] fi,
                                 input logic mp, input logic [2:0] mi, input logic cr);
        bit     exp_ready, exp_valid, grant, fire, accept;
        int     pos;
        entry_t e;
        in_rst_n           = 1'b1;
        in_alloc_valid     = av;
        in_alloc_gpr_idx   = ag;
        in_alloc_is_nop    = an;
        in_fu_done         = fd;
        in_fu_rob_idx      = fi;
        in_mispred         = mp;
        in_mispred_rob_idx = mi;
        in_commit_ready    = cr;
        #1;
        exp_ready = !m_flush && m_q.size() < 8 && !mp;
        exp_valid = !m_flush && m_q.size() > 0 && m_q[0].done;
        checkOutput("alloc_ready", 32'(out_alloc_ready), 32'(exp_ready));
        checkOutput("alloc_idx", 32'(out_alloc_idx), 32'((m_head + m_q.size()) % 8));
        checkOutput("commit_valid", 32'(out_commit_valid), 32'(exp_valid));
        checkOutput("commit_idx", 32'(out_commit_idx), 32'(m_head));
        checkOutput("count", 32'(out_count), 32'(m_q.size()));
        checkOutput("should_commit", 32'(out_regfile_should_commit), 32'(exp_valid && !m_q[0].nop));
        if (exp_valid) checkOutput("commit_gpr", 32'(out_commit_gpr_idx), 32'(m_q[0].gpr));
        grant = av && exp_ready;
        fire  = exp_valid && cr;
        pos   = -1;
        if (mp && !m_flush)
            foreach (m_q[k]) if (m_q[k].idx == int'(mi)) pos = k;
        accept = (pos >= 0);
        @(posedge in_clk);
        if (fire) begin
            void'(m_q.pop_front());
            m_head = (m_head + 1) % 8;
            pos--;
        end
        if (fd) foreach (m_q[k]) if (m_q[k].idx == int'(fi)) m_q[k].done = 1'b1;
        if (accept) while (m_q.size() > pos + 1) void'(m_q.pop_back());
        if (grant) begin
            e.idx  = (m_head + m_q.size()) % 8;
            e.gpr  = int'(ag);
            e.nop  = an;
            e.done = 1'b0;
            m_q.push_back(e);
        end
        m_flush = accept;
        @(negedge in_clk);
    endtask

    task automatic idle(input int cycles, input logic cr);
        for (int c = 0; c < cycles; c++) applyStimulus(0, 0, 0, 0, 0, 0, 0, cr);
    endtask

    initial begin
        in_rst_n = 1'b0;
        in_alloc_valid = 0; in_alloc_gpr_idx = 0; in_alloc_is_nop = 0;
        in_fu_done = 0; in_fu_rob_idx = 0; in_mispred = 0; in_mispred_rob_idx = 0;
        in_commit_ready = 0;
        @(negedge in_clk);
        applyReset(2);

        // Fill, ninth request refused, then out-of-order completion retires in order.
        for (int i = 0; i < 8; i++) applyStimulus(1, 5'(i + 3), 1'(i == 4), 0, 0, 0, 0, 0);
        applyStimulus(1, 5'd9, 0, 0, 0, 0, 0, 0);
        checkOutput("full_count", 32'(out_count), 32'd8);
        applyStimulus(0, 0, 0, 1, 3'd2, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 3'd0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 3'd1, 0, 0, 1);
        idle(3, 1);
        checkOutput("after_three_commits_head", 32'(out_commit_idx), 32'd3);

        // Full ROB with head done: commit fires while alloc still refused; slot usable next cycle.
        applyReset(1);
        for (int i = 0; i < 8; i++) applyStimulus(1, 5'(i), 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 3'd0, 0, 0, 0);
        idle(3, 0);
        applyStimulus(1, 5'd17, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 5'd18, 0, 0, 0, 0, 0, 0);

        // Move head to 6, refill to tail 3, mispredict at 7, then a late done on a squashed entry.
        applyReset(1);
        for (int i = 0; i < 6; i++) applyStimulus(1, 5'(i), 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 3'(i), 0, 0, 1);
        idle(3, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 5'(20 + i), 0, 0, 0, 0, 0, 0);
        checkOutput("pre_mp_count", 32'(out_count), 32'd5);
        applyStimulus(0, 0, 0, 0, 0, 1, 3'd7, 0);
        checkOutput("mp_count", 32'(out_count), 32'd2);
        checkOutput("mp_tail", 32'(out_alloc_idx), 32'd0);
        applyStimulus(0, 0, 0, 1, 3'd1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 3'd6, 0, 0, 1);
        idle(4, 1);

        // Mispredict on an idle index, then reset arriving during the flush cycle.
        applyReset(1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 5'(i), 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 3'd5, 0);
        applyStimulus(1, 5'd4, 0, 0, 0, 1, 3'd1, 0);
        applyReset(1);
        idle(1, 1);

        // Mispredict in the same cycle the head retires.
        for (int i = 0; i < 4; i++) applyStimulus(1, 5'(i), 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 3'd0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 3'd2, 1);
        checkOutput("mp_fire_count", 32'(out_count), 32'd2);
        idle(2, 1);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            logic [2:0] fi, mi;
            if ($urandom_range(0, 299) == 0) applyReset($urandom_range(1, 2));
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0) fi = 3'(m_q[$urandom_range(0, m_q.size() - 1)].idx);
            else fi = 3'($urandom);
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0) mi = 3'(m_q[$urandom_range(0, m_q.size() - 1)].idx);
            else mi = 3'($urandom);
            applyStimulus(1'($urandom_range(0, 9) < 6), 5'($urandom), 1'($urandom_range(0, 4) == 0),
                          1'($urandom_range(0, 9) < 6), fi,
                          1'($urandom_range(0, 15) == 0), mi,
                          1'($urandom_range(0, 9) < 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
